// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit path: data width, FIFO sizing
// defaults and the launch FSM state encoding.
package uart_tx_feeder_pkg;

  localparam int DATA_W           = 8;
  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_ADDR_W = 4;

  typedef enum logic [1:0] {
    TXF_IDLE      = 2'd0,
    TXF_LAUNCH    = 2'd1,
    TXF_WAIT_BUSY = 2'd2,
    TXF_WAIT_DONE = 2'd3
  } txf_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock byte FIFO with wrapping pointers, an explicit occupancy count
// and a synchronous flush. Storage is not reset; only pointers and level are.
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   LVL_ONE = 1;
  localparam logic [ADDR_W:0]   LVL_MAX = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level_q == LVL_MAX);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // Flush overrides both ports so a same-edge write is discarded.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a uart_tx: pops one byte at a time and hands it over
// with a registered one-cycle start pulse, pacing on the transmitter's busy flag.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   level
);

  txf_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (in_data),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign in_ready = ~fifo_full;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  // A pop is only issued from IDLE with flush low, so flush never races a launch.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      TXF_IDLE: begin
        if (!fifo_empty && !tx_busy && !flush) begin
          pop       = 1'b1;
          tx_data_d = head_data;
          state_d   = TXF_LAUNCH;
        end
      end
      TXF_LAUNCH: begin
        state_d = TXF_WAIT_BUSY;
      end
      TXF_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = TXF_WAIT_DONE;
        end
      end
      TXF_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = TXF_IDLE;
        end
      end
      default: begin
        state_d = TXF_IDLE;
      end
    endcase
    tx_start_d = (state_d == TXF_LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TXF_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

endmodule
